// File: rtl/seq3_checker.sv
// Checks a 3-bit step-sequence generator for correct code order and dwell time.
// It acquires lock on the first clean step and counts errors and wraps.
module seq3_checker #(
   parameter int STEP = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in0,
   input  logic       in1,
   input  logic       in2,
   output logic       lock,
   output logic       err,
   output logic       and_hit,
   output logic [7:0] err_cnt,
   output logic [7:0] wrap_cnt
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACQ,
      S_LOCK
   } state_t;

   localparam logic [7:0] STEP_C = 8'(STEP);

   state_t     state_q, state_d;
   logic [2:0] prev_q, prev_d;
   logic [7:0] dwell_q, dwell_d;
   logic       lock_q, lock_d;
   logic       err_q, err_d;
   logic       and_hit_q, and_hit_d;
   logic [7:0] err_cnt_q, err_cnt_d;
   logic [7:0] wrap_cnt_q, wrap_cnt_d;

   logic [2:0] v;
   logic [2:0] succ;
   logic       viol;
   logic       step_ok;

   assign v    = {in0, in1, in2};
   assign succ = prev_q + 3'd1;

   always_comb begin
      state_d = state_q;
      prev_d  = prev_q;
      dwell_d = dwell_q;
      viol    = 1'b0;
      step_ok = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            prev_d  = v;
            dwell_d = 8'd1;
            state_d = S_ACQ;
         end
         S_ACQ: begin
            if (v == succ) begin
               prev_d  = v;
               dwell_d = 8'd1;
               state_d = S_LOCK;
            end else begin
               prev_d = v;
            end
         end
         S_LOCK: begin
            if (v == prev_q) begin
               if (dwell_q < STEP_C) dwell_d = dwell_q + 8'd1;
               else                  viol    = 1'b1;
            end else if (dwell_q < STEP_C) begin
               viol = 1'b1;
            end else if (v == succ) begin
               step_ok = 1'b1;
               prev_d  = v;
               dwell_d = 8'd1;
            end else begin
               viol = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // every violation drops back to acquisition on the offending code
      if (viol) begin
         prev_d  = v;
         dwell_d = 8'd1;
         state_d = S_ACQ;
      end
   end

   always_comb begin
      lock_d     = (state_d == S_LOCK);
      err_d      = viol;
      and_hit_d  = step_ok && (prev_q == 3'd6);
      err_cnt_d  = err_cnt_q;
      wrap_cnt_d = wrap_cnt_q;
      if (viol && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
      if (step_ok && (prev_q == 3'd7)) wrap_cnt_d = wrap_cnt_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         prev_q     <= 3'd0;
         dwell_q    <= 8'd0;
         lock_q     <= 1'b0;
         err_q      <= 1'b0;
         and_hit_q  <= 1'b0;
         err_cnt_q  <= 8'd0;
         wrap_cnt_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         prev_q     <= prev_d;
         dwell_q    <= dwell_d;
         lock_q     <= lock_d;
         err_q      <= err_d;
         and_hit_q  <= and_hit_d;
         err_cnt_q  <= err_cnt_d;
         wrap_cnt_q <= wrap_cnt_d;
      end
   end

   assign lock     = lock_q;
   assign err      = err_q;
   assign and_hit  = and_hit_q;
   assign err_cnt  = err_cnt_q;
   assign wrap_cnt = wrap_cnt_q;

endmodule

// File: tb/tb_seq3_checker.sv
// Directed bench for seq3_checker with STEP=2.
// Expected values are hand-derived from the code sequence driven.
module tb_seq3_checker;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in0 = 1'b0;
   logic       in1 = 1'b0;
   logic       in2 = 1'b0;
   logic       lock;
   logic       err;
   logic       and_hit;
   logic [7:0] err_cnt;
   logic [7:0] wrap_cnt;

   int total = 0;
   int bad   = 0;

   seq3_checker #(.STEP(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .in0      (in0),
      .in1      (in1),
      .in2      (in2),
      .lock     (lock),
      .err      (err),
      .and_hit  (and_hit),
      .err_cnt  (err_cnt),
      .wrap_cnt (wrap_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // drive one code, then look at the registered result just after the edge
   task automatic send(input logic [2:0] v);
      @(negedge clk);
      {in0, in1, in2} = v;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [2:0] p;
      int exp_wrap;
      int exp_ec;

      // reset state
      rst = 1'b1;
      send(3'd0);
      send(3'd0);
      chk("rst_lock", lock, 0);
      chk("rst_err", err, 0);
      chk("rst_and", and_hit, 0);
      chk("rst_ecnt", err_cnt, 0);
      chk("rst_wcnt", wrap_cnt, 0);
      rst = 1'b0;

      // three clean periods 0,0,1,1,...,7,7
      exp_wrap = 0;
      for (int i = 0; i < 48; i++) begin
         send(3'((i % 16) / 2));
         if (i > 0 && (i % 16) == 0) exp_wrap++;
         chk("run_lock", lock, (i >= 2) ? 1 : 0);
         chk("run_err", err, 0);
         chk("run_and", and_hit, ((i % 16) == 14) ? 1 : 0);
         chk("run_wrap", wrap_cnt, exp_wrap);
      end
      send(3'd0);
      chk("wrap3", wrap_cnt, 3);
      chk("wrap3_lock", lock, 1);
      send(3'd0);

      // jump violation 2 -> 4, then reacquire on 4 -> 5
      send(3'd1); send(3'd1); send(3'd2); send(3'd2);
      chk("pre_jump_lock", lock, 1);
      send(3'd4);
      chk("jump_err", err, 1);
      chk("jump_lock", lock, 0);
      chk("jump_ecnt", err_cnt, 1);
      send(3'd4);
      chk("acq_err", err, 0);
      chk("acq_lock", lock, 0);
      send(3'd5);
      chk("reacq_lock", lock, 1);
      chk("reacq_err", err, 0);
      send(3'd5);
      chk("reacq_err2", err, 0);

      // short dwell: 4 held one cycle
      send(3'd6); send(3'd6);
      send(3'd7);
      chk("and_pulse", and_hit, 1);
      send(3'd7);
      chk("and_one", and_hit, 0);
      send(3'd0);
      chk("wrap4", wrap_cnt, 4);
      send(3'd0); send(3'd1); send(3'd1); send(3'd2); send(3'd2);
      send(3'd3); send(3'd3); send(3'd4);
      chk("short_pre_err", err, 0);
      send(3'd5);
      chk("short_err", err, 1);
      chk("short_ecnt", err_cnt, 2);
      chk("short_lock", lock, 0);

      // acquisition 5 -> 6, then long dwell on 5
      send(3'd6);
      chk("acq6_lock", lock, 1);
      chk("acq6_and", and_hit, 0);
      send(3'd6);
      send(3'd7);
      chk("and_pulse2", and_hit, 1);
      send(3'd7);
      send(3'd0);
      chk("wrap5", wrap_cnt, 5);
      send(3'd0); send(3'd1); send(3'd1); send(3'd2); send(3'd2);
      send(3'd3); send(3'd3); send(3'd4); send(3'd4); send(3'd5);
      send(3'd5);
      chk("long_pre_lock", lock, 1);
      send(3'd5);
      chk("long_err", err, 1);
      chk("long_lock", lock, 0);
      chk("long_ecnt", err_cnt, 3);

      // acquisition is silent on jumps and ignores 6 -> 7 for and_hit
      send(3'd3);
      chk("acq_jump_err", err, 0);
      send(3'd6);
      chk("acq_jump_err2", err, 0);
      chk("acq_jump_lock", lock, 0);
      send(3'd7);
      chk("acq67_lock", lock, 1);
      chk("acq67_and", and_hit, 0);
      send(3'd7);
      send(3'd0);
      chk("wrap6", wrap_cnt, 6);
      chk("ecnt_hold", err_cnt, 3);

      // mid-operation reset clears everything; re-lock needs fresh acquisition
      rst = 1'b1;
      send(3'd1);
      rst = 1'b0;
      chk("mrst_lock", lock, 0);
      chk("mrst_err", err, 0);
      chk("mrst_and", and_hit, 0);
      chk("mrst_ecnt", err_cnt, 0);
      chk("mrst_wcnt", wrap_cnt, 0);
      send(3'd1);
      chk("post_rst_lock", lock, 0);
      chk("post_rst_err", err, 0);
      send(3'd2);
      chk("relock", lock, 1);

      // 300 jump violations saturate err_cnt at 255
      rst = 1'b1;
      send(3'd0);
      rst = 1'b0;
      send(3'd0);
      p = 3'd0;
      exp_ec = 0;
      for (int i = 0; i < 300; i++) begin
         send(p + 3'd1);
         chk("sat_lock", lock, 1);
         send(p + 3'd1);
         send(p + 3'd5);
         if (exp_ec < 255) exp_ec++;
         chk("sat_err", err, 1);
         chk("sat_ecnt", err_cnt, exp_ec);
         p = p + 3'd5;
      end
      chk("sat_final", err_cnt, 255);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
